// File: rtl/square_pkg.sv
// Shared types and constants for the sequential squarer (square_seq).
// Optional macro SQUARE_SEQ_RADIX4_EN selects two root bits per step.
package square_pkg;

    localparam int SQ_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Edges from the accepting edge until out_valid is high.
    function automatic int sq_lat(input int w, input bit radix4);
        return radix4 ? (w / 2) : w;
    endfunction

endpackage

// File: rtl/square_step.sv
// One MSB-first digit of the square recurrence: adding root bit i to p
// grows the running square by (p << (i+1)) + (1 << 2i).
module square_step
    import square_pkg::*;
#(
    parameter int W = SQ_W_DEFAULT
) (
    input  logic [2*W-1:0]         acc,
    input  logic [W-1:0]           p,
    input  logic [$clog2(W)-1:0]   i,
    input  logic                   q_bit,
    output logic [2*W-1:0]         acc_nxt,
    output logic [W-1:0]           p_nxt
);

    logic [2*W-1:0] cross_term;
    logic [2*W-1:0] square_term;

    // NOTE: every output gets a default before the conditional update, so no latch is inferred.
    always_comb begin
        cross_term  = (2*W)'(p) << (32'(i) + 32'd1);
        square_term = (2*W)'(1) << (32'(i) << 1);
        acc_nxt     = acc;
        p_nxt       = p;
        if (q_bit) begin
            acc_nxt = acc + cross_term + square_term;
            p_nxt   = p | (W'(1) << i);
        end
    end

endmodule

// File: rtl/square_seq.sv
// Sequential integer squarer z = q*q, one root bit per clock with valid/ready
// handshakes; define SQUARE_SEQ_RADIX4_EN to process two root bits per clock.
module square_seq
    import square_pkg::*;
#(
    parameter int W = SQ_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z
);

    localparam int CW = $clog2(W);

`ifdef SQUARE_SEQ_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
    localparam logic [CW-1:0] CNT_STEP = RADIX4 ? CW'(2) : CW'(1);
    localparam logic [CW-1:0] CNT_LAST = RADIX4 ? CW'(1) : CW'(0);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     q_lat;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     p;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   acc_step;
    logic [W-1:0]     p_step;
    logic             accept;
    logic             last;

`ifdef SQUARE_SEQ_RADIX4_EN
    if ((W % 2) != 0) begin : g_w_odd
        $error("square_seq: W must be even when SQUARE_SEQ_RADIX4_EN is defined");
    end

    logic [2*W-1:0]   acc_mid;
    logic [W-1:0]     p_mid;
    logic [CW-1:0]    cnt_lo;

    assign cnt_lo = cnt - CW'(1);

    square_step #(.W(W)) u_step_hi (
        .acc     (acc),
        .p       (p),
        .i       (cnt),
        .q_bit   (q_lat[cnt]),
        .acc_nxt (acc_mid),
        .p_nxt   (p_mid)
    );

    square_step #(.W(W)) u_step_lo (
        .acc     (acc_mid),
        .p       (p_mid),
        .i       (cnt_lo),
        .q_bit   (q_lat[cnt_lo]),
        .acc_nxt (acc_step),
        .p_nxt   (p_step)
    );
`else
    square_step #(.W(W)) u_step (
        .acc     (acc),
        .p       (p),
        .i       (cnt),
        .q_bit   (q_lat[cnt]),
        .acc_nxt (acc_step),
        .p_nxt   (p_step)
    );
`endif

    assign last      = (cnt == CNT_LAST);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // in_ready is masked by rst so nothing is accepted during the reset cycle.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q_lat <= '0;
            acc   <= '0;
            p     <= '0;
            cnt   <= '0;
            z     <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        q_lat <= q;
                        acc   <= '0;
                        p     <= '0;
                        cnt   <= CNT_INIT;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    p   <= p_step;
                    if (last) begin
                        z <= acc_step;
                    end else begin
                        cnt <= cnt - CNT_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq: directed corner cases plus random
// operands against an arithmetic q*q reference and a handshake timing model.
module tb_square_seq;
    import square_pkg::*;

    localparam int W = SQ_W_DEFAULT;
`ifdef SQUARE_SEQ_RADIX4_EN
    localparam int LAT = W / 2;
`else
    localparam int LAT = W;
`endif
    localparam int N_B2B = 1 << W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     q;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   z;

    int checks;
    int errors;

    square_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_square(input logic [W-1:0] v);
        logic [2*W-1:0] a;
        a = (2*W)'(v);
        return a * a;
    endfunction

    // One transaction: accept qv, measure latency, hold out_ready low for
    // stall cycles while poking in_valid, then complete the handshake.
    task automatic do_op(input logic [W-1:0] qv, input int stall, input string tag);
        int n;
        bit saw_ready;
        logic [2*W-1:0] exp_z;
        exp_z = ref_square(qv);
        check({tag, "_idle_ready"}, in_ready, 1);
        q         = qv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        q         = W'($urandom);
        n         = 0;
        saw_ready = 1'b0;
        while (!out_valid && n <= 4 * W + 8) begin
            if (in_ready) saw_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_ready"}, saw_ready, 0);
        check({tag, "_latency"}, n, LAT);
        check({tag, "_z"}, z, exp_z);
        for (int s = 0; s < stall; s++) begin
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_z"}, z, exp_z);
            check({tag, "_stall_ready"}, in_ready, 0);
            in_valid = 1'($urandom);
            q        = W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_ready"}, in_ready, 1);
        check({tag, "_post_z"}, z, exp_z);
    endtask

    initial begin
        logic [2*W-1:0] exp_q[$];
        int  cyc;
        int  last_acc;
        int  accepted;
        int  popped;
        bit  saw_valid;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        q         = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_z", z, 0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1);
        @(negedge clk);

        do_op(W'(8'hB5), 0, "b5");
        do_op(W'(8'h00), 0, "zero");
        do_op(W'(8'h01), 0, "one");
        do_op(W'(8'hFF), 0, "ff");
        do_op(W'(8'h10), 5, "stall10");

        // Reset three edges into CALC discards the result.
        q        = W'(8'hC8);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_z", z, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready", in_ready, 1);
        saw_valid = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst_no_result", saw_valid, 0);
        do_op(W'(8'h03), 0, "after_rst");

        for (int k = 0; k < 20; k++) begin
            do_op(W'($urandom), $urandom_range(0, 3), "rand");
        end

        // Back-to-back stream: q steps through every value with in_valid held.
        out_ready = 1'b1;
        cyc       = 0;
        last_acc  = 0;
        accepted  = 0;
        popped    = 0;
        while (popped < N_B2B && cyc < N_B2B * (LAT + 2) + 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious_result", 1, 0);
                end else begin
                    check("b2b_z", z, exp_q.pop_front());
                end
                popped++;
            end
            if (accepted < N_B2B) begin
                q        = W'(accepted);
                in_valid = 1'b1;
                if (in_ready) begin
                    exp_q.push_back(ref_square(q));
                    if (accepted > 0) check("b2b_period", cyc - last_acc, LAT + 2);
                    last_acc = cyc;
                    accepted++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_accepted", accepted, N_B2B);
        check("b2b_results", popped, N_B2B);
        check("b2b_leftover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
